// File: rtl/sram_lane_array.sv
// sram_lane_array: lane-masked single-port array with a credit-managed in-order read-response FIFO
module sram_lane_array #(
    parameter int ADDR_W        = 12,
    parameter int LANES         = 4,
    parameter int LANE_W        = 8,
    parameter int RSP_DEPTH     = 3,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [LANES*LANE_W-1:0]   req_wdata,
    input  logic [LANES-1:0]          req_wmask,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [LANES*LANE_W-1:0]   rsp_rdata,
    output logic                      init_busy
);
    localparam int W = LANES * LANE_W;
    localparam int PW = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0] DEP = PW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] fill;
    logic [W-1:0]      rd_q;
    logic [W-1:0]      fifo [2**PW];
    logic              rd_pend, rd_acc, wr_acc, pop, fill_we;
    logic [PW-1:0]     cnt, wp, rp, outstanding;

    always_comb begin
        state_nx  = state;
        fill_we   = 1'b0;
        init_busy = 1'b0;
        if (state == INIT) begin
            fill_we   = 1'b1;
            init_busy = 1'b1;
            state_nx  = (fill == '1) ? RUN : INIT;
        end
    end

    // credits cover both the registered read in flight and every queued response
    assign outstanding = cnt + PW'(rd_pend);
    assign req_ready   = rst_n && state == RUN && (req_write || outstanding < DEP);
    assign rd_acc      = req_valid && req_ready && !req_write;
    assign wr_acc      = req_valid && req_ready && req_write;
    assign rsp_valid   = cnt != '0;
    assign pop         = rsp_valid && rsp_ready;
    assign rsp_rdata   = rsp_valid ? fifo[rp] : '0;

    genvar l;
    for (l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_W-1:0] m [2**ADDR_W];
        logic [LANE_W-1:0] q;
        always_ff @(posedge clk) begin
            if (fill_we || (wr_acc && req_wmask[l]))
                m[fill_we ? fill : req_addr] <= fill_we ? '0 : req_wdata[l*LANE_W +: LANE_W];
            if (rd_acc)
                q <= m[req_addr];
        end
        assign rd_q[l*LANE_W +: LANE_W] = q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= (INIT_ON_RESET != 0) ? INIT : RUN;
            fill    <= '0;
            rd_pend <= 1'b0;
            cnt     <= '0;
            wp      <= '0;
            rp      <= '0;
        end else begin
            state   <= state_nx;
            fill    <= fill_we ? fill + 1'b1 : fill;
            rd_pend <= rd_acc;
            cnt     <= cnt + PW'(rd_pend) - PW'(pop);
            if (rd_pend) begin
                fifo[wp] <= rd_q;
                wp       <= (wp == LAST) ? '0 : wp + 1'b1;
            end
            if (pop)
                rp <= (rp == LAST) ? '0 : rp + 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_lane_array.sv
// tb_sram_lane_array: directed and random checks against a queue-based behavioural model
module tb_sram_lane_array;
    logic        clk, rst_n, req_valid, req_ready, req_write, rsp_valid, rsp_ready, init_busy;
    logic [3:0]  req_addr, req_wmask;
    logic [31:0] req_wdata, rsp_rdata;

    sram_lane_array #(.ADDR_W(4), .LANES(4), .LANE_W(8), .RSP_DEPTH(3), .INIT_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .init_busy(init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; int t; } ent_t;
    ent_t        q[$];
    logic [31:0] mm [16];
    int          now, init_left, total, bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one cycle: drive, compare every output with the model, then advance the model
    task automatic cyc(input logic v, input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic rr);
        logic run_m, rdy_m, rv_m;
        logic [31:0] bm;
        req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wmask = m; rsp_ready = rr;
        #1;
        run_m = init_left == 0;
        rdy_m = run_m && (w || q.size() < 3);
        rv_m  = q.size() > 0 && now - q[0].t >= 2;
        chk("req_ready", req_ready, rdy_m);
        chk("init_busy", init_busy, !run_m);
        chk("rsp_valid", rsp_valid, rv_m);
        chk("rsp_rdata", rsp_rdata, rv_m ? q[0].d : 32'h0);
        if (rv_m && rr) void'(q.pop_front());
        if (v && rdy_m) begin
            if (w) begin
                bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
                mm[a] = (mm[a] & ~bm) | (d & bm);
            end else q.push_back('{d: mm[a], t: now});
        end
        if (init_left > 0) init_left--;
        @(negedge clk);
        now++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
        #1;
        chk("reset_ready", req_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        init_left = 16;
        for (int i = 0; i < 16; i++) mm[i] = 32'h0;
    endtask

    initial begin
        total = 0; bad = 0; now = 0;
        do_reset();
        chk("init_busy_after_reset", init_busy, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 4'(i), 32'h0, 4'h0, 1'b1);
        chk("first_run_ready", req_ready, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 4'(i), 32'h0, 4'h0, 1'b1);
        idle(3);

        cyc(1'b1, 1'b1, 4'h5, 32'hAABBCCDD, 4'b1111, 1'b1);
        cyc(1'b1, 1'b1, 4'h5, 32'h11223344, 4'b0101, 1'b1);
        cyc(1'b1, 1'b0, 4'h5, 32'h0, 4'h0, 1'b1);
        idle(1);
        chk("masked_read", rsp_rdata, 32'hAA22CC44);
        idle(2);

        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 4'(i), 32'h0, 4'h0, 1'b1);
        idle(4);

        for (int i = 6; i <= 10; i++) cyc(1'b1, 1'b0, 4'(i), 32'h0, 4'h0, 1'b0);
        chk("bp_full_read_blocked", req_ready, 1'b0);
        cyc(1'b1, 1'b1, 4'h9, 32'hCAFEF00D, 4'b0011, 1'b0);
        idle(5);

        cyc(1'b1, 1'b1, 4'h3, 32'h12345678, 4'b1111, 1'b1);
        cyc(1'b1, 1'b0, 4'h3, 32'h0, 4'h0, 1'b1);
        idle(1);
        chk("read_after_write", rsp_rdata, 32'h12345678);
        idle(2);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
        idle(4);

        cyc(1'b1, 1'b0, 4'h3, 32'h0, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 4'h5, 32'h0, 4'h0, 1'b0);
        do_reset();
        chk("rsp_valid_after_reset", rsp_valid, 1'b0);
        idle(16);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 4'(i), 32'h0, 4'h0, 1'b1);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
